// File: rtl/regfile_wb_port_pkg.sv
// Shared CPU-side definitions for the register-file write-side front end.
package regfile_wb_port_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // One buffered long-latency result: destination register plus value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    // Writes to r0 are consumed but never reach the register file.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] a);
        return a == ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_wb_port_wb_fifo.sv
// Small synchronous FIFO holding MDU results until the write port is free.
// Pointers carry one extra MSB so full and empty are distinguishable.
module wb_fifo
    import regfile_wb_port_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    wb_req_t        mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q[PTR_W-1:0]];

    // Next pointer values: advance on accepted push/pop, wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    // Pointer registers; clearing them discards all buffered entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents need no reset since the pointers gate validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= push_req;
        end
    end

endmodule

// File: rtl/regfile_wb_port.sv
// Register-file write-port front end: arbitrates pipeline write-back against
// buffered MDU results, forces a one-cycle pipeline hold when a buffered
// result waits too long, and tracks registers with results still in flight.
module regfile_wb_port
    import regfile_wb_port_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_addr,
    input  logic [DATA_W-1:0]     md_data,
    output logic                  md_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic                  rs_ena,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic                  rt_ena,
    output logic                  hazard_src,
    output logic                  hazard_dst,
    output logic                  wb_hold,
    output logic                  rd_wena,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    // Wide enough to hold STARVE_LIMIT+1 without wrapping.
    localparam int AGE_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [AGE_W-1:0] AGE_MAX   = '1;
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    wb_req_t               fifo_head;
    wb_req_t               fifo_in;

    logic                  sel_wb;
    logic                  rd_wena_q, rd_wena_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic [AGE_W-1:0]      head_age_q, head_age_d;
    logic                  wb_hold_q, wb_hold_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;

    // md_ready looks only at current occupancy: no push-through when full.
    assign md_ready  = !fifo_full;
    assign fifo_push = md_valid && !fifo_full;
    assign fifo_in   = '{addr: md_addr, data: md_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_req (fifo_in),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Write-port arbitration: pipeline first unless held, then FIFO head.
    always_comb begin
        sel_wb    = wb_valid && !wb_hold_q;
        fifo_pop  = !sel_wb && !fifo_empty;
        rd_wena_d = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (sel_wb) begin
            rd_wena_d = !is_zero_reg(wb_addr);
            rd_addr_d = wb_addr;
            rd_data_d = wb_data;
        end else if (fifo_pop) begin
            rd_wena_d = !is_zero_reg(fifo_head.addr);
            rd_addr_d = fifo_head.addr;
            rd_data_d = fifo_head.data;
        end
    end

    // Starvation tracking: age of the current head; hold the pipeline for
    // one cycle once the head has waited STARVE_LIMIT cycles unserved.
    always_comb begin
        head_age_d = head_age_q;
        wb_hold_d  = 1'b0;
        if (fifo_empty || fifo_pop) begin
            head_age_d = '0;
        end else if (head_age_q != AGE_MAX) begin
            head_age_d = head_age_q + AGE_W'(1);
        end
        if (!fifo_empty && !fifo_pop && head_age_q == AGE_LIMIT) begin
            wb_hold_d = 1'b1;
        end
    end

    // Scoreboard next state per register: a new issue wins over a same-edge
    // clear from the FIFO pop of that register.
    assign pending_d[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_pending
            assign pending_d[gi] =
                (issue_valid && issue_addr == REG_ADDR_W'(gi)) ||
                (pending_q[gi] && !(fifo_pop && fifo_head.addr == REG_ADDR_W'(gi)));
        end
    endgenerate

    // State registers for the write port, starvation logic and scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_wena_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            head_age_q <= '0;
            wb_hold_q  <= 1'b0;
            pending_q  <= '0;
        end else begin
            rd_wena_q  <= rd_wena_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            head_age_q <= head_age_d;
            wb_hold_q  <= wb_hold_d;
            pending_q  <= pending_d;
        end
    end

    assign rd_wena    = rd_wena_q;
    assign rd_addr    = rd_addr_q;
    assign rd_data    = rd_data_q;
    assign wb_hold    = wb_hold_q;
    assign hazard_src = (rs_ena && pending_q[rs_addr]) ||
                        (rt_ena && pending_q[rt_addr]);
    assign hazard_dst = pending_q[issue_addr] && !is_zero_reg(issue_addr);

endmodule

// File: tb/tb_regfile_wb_port.sv
// Bench for regfile_wb_port: directed scenarios plus random traffic, each
// cycle checked against a queue-based reference model.
module tb_regfile_wb_port;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, md_valid, issue_valid, rs_ena, rt_ena;
    logic [4:0]  wb_addr, md_addr, issue_addr, rs_addr, rt_addr;
    logic [31:0] wb_data, md_data;
    logic        md_ready, hazard_src, hazard_dst, wb_hold, rd_wena;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    regfile_wb_port #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data),
        .md_ready(md_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rs_addr(rs_addr), .rs_ena(rs_ena), .rt_addr(rt_addr), .rt_ena(rt_ena),
        .hazard_src(hazard_src), .hazard_dst(hazard_dst), .wb_hold(wb_hold),
        .rd_wena(rd_wena), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: buffered results in arrival order, pending flags,
    // and the cycle at which the current head started waiting.
    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t        q[$];
    bit          pend[32];
    bit          m_hold;
    bit          m_wena;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          cyc;
    int          head_since;
    bit          last_md_acc;

    task automatic model_reset();
        q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        m_hold = 0; m_wena = 0; m_addr = '0; m_data = '0;
        cyc = 0; head_since = 0;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_addr = '0; wb_data = '0;
        md_valid = 0; md_addr = '0; md_data = '0;
        issue_valid = 0; issue_addr = '0;
        rs_ena = 0; rs_addr = '0; rt_ena = 0; rt_addr = '0;
    endtask

    // One clock cycle: inputs already driven; compare, advance model, clock.
    task automatic cycle();
        bit   exp_ready, exp_src, exp_dst, popped, hold_next;
        int   sz;
        ent_t e;
        #1;
        exp_ready = (q.size() < DEPTH);
        exp_src   = (rs_ena && pend[rs_addr]) || (rt_ena && pend[rt_addr]);
        exp_dst   = pend[issue_addr] && issue_addr != 0;
        chk("md_ready", md_ready, exp_ready);
        chk("hazard_src", hazard_src, exp_src);
        chk("hazard_dst", hazard_dst, exp_dst);
        chk("wb_hold", wb_hold, m_hold);
        chk("rd_wena", rd_wena, m_wena);
        if (m_wena) begin
            chk("rd_addr", rd_addr, m_addr);
            chk("rd_data", rd_data, m_data);
        end
        popped = 0;
        sz = q.size();
        if (!m_hold && wb_valid) begin
            m_wena = (wb_addr != 0); m_addr = wb_addr; m_data = wb_data;
        end else if (sz > 0) begin
            e = q.pop_front();
            popped = 1;
            m_wena = (e.a != 0); m_addr = e.a; m_data = e.d;
            pend[e.a] = 1'b0;
        end else begin
            m_wena = 0;
        end
        hold_next = !popped && sz > 0 && (cyc - head_since == LIMIT);
        last_md_acc = md_valid && exp_ready;
        if (last_md_acc) begin
            e.a = md_addr; e.d = md_data;
            q.push_back(e);
        end
        if (popped || (last_md_acc && sz == 0)) head_since = cyc + 1;
        if (issue_valid && issue_addr != 0) pend[issue_addr] = 1'b1;
        pend[0] = 1'b0;
        m_hold = hold_next;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [4:0] rand_addr();
        case ($urandom % 6)
            0: return 5'd0;
            1: return 5'd17;
            2: return 5'd18;
            3: return 5'd19;
            4: return 5'd20;
            default: return 5'($urandom % 32);
        endcase
    endfunction

    initial begin
        int   k;
        bit   md_have;
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset rd_wena", rd_wena, 1'b0);
        chk("reset rd_addr", rd_addr, 5'd0);
        chk("reset rd_data", rd_data, 32'd0);
        chk("reset wb_hold", wb_hold, 1'b0);
        chk("reset md_ready", md_ready, 1'b1);
        rst_n = 1;
        @(negedge clk);

        // Pipeline write lands one cycle later.
        wb_valid = 1; wb_addr = 5'd17; wb_data = 32'h1234;
        cycle();
        idle_inputs();
        #1;
        chk("wb17 rd_wena", rd_wena, 1'b1);
        chk("wb17 rd_addr", rd_addr, 5'd17);
        chk("wb17 rd_data", rd_data, 32'h1234);
        cycle();

        // Issue r18, MDU result arrives later; hazard clears when written.
        issue_valid = 1; issue_addr = 5'd18;
        cycle();
        issue_valid = 0;
        rs_ena = 1; rs_addr = 5'd18;
        md_valid = 1; md_addr = 5'd18; md_data = 32'hCAFE;
        cycle();
        md_valid = 0;
        cycle();
        #1;
        chk("mdu18 rd_wena", rd_wena, 1'b1);
        chk("mdu18 rd_data", rd_data, 32'hCAFE);
        chk("mdu18 hazard_src", hazard_src, 1'b0);
        cycle();
        idle_inputs();

        // Starvation: pipeline busy every cycle, three MDU results queued.
        k = 0;
        for (int c = 0; c < 24; c++) begin
            wb_valid = !m_hold; wb_addr = 5'd21; wb_data = 32'($urandom);
            md_valid = (k < 3); md_addr = 5'(k + 1); md_data = 32'hA000 + 32'(k);
            cycle();
            if (last_md_acc) k++;
        end
        idle_inputs();
        repeat (4) cycle();

        // Result to r0 is consumed without a write; pending bits untouched.
        issue_valid = 1; issue_addr = 5'd19;
        cycle();
        idle_inputs();
        md_valid = 1; md_addr = 5'd0; md_data = 32'hDEAD;
        rs_ena = 1; rs_addr = 5'd19;
        cycle();
        md_valid = 0;
        cycle();
        cycle();
        idle_inputs();

        // Re-issue of r18 on the same edge its older result pops.
        issue_valid = 1; issue_addr = 5'd18;
        cycle();
        idle_inputs();
        md_valid = 1; md_addr = 5'd18; md_data = 32'h5555;
        cycle();
        md_valid = 0;
        issue_valid = 1; issue_addr = 5'd18;
        cycle();
        issue_valid = 0; issue_addr = 5'd18;
        #1;
        chk("reissue hazard_dst", hazard_dst, 1'b1);
        cycle();
        idle_inputs();

        // Random traffic with a well-behaved MDU source and pipeline.
        md_have = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!md_have && ($urandom % 3 == 0)) begin
                md_have = 1; md_addr = rand_addr(); md_data = 32'($urandom);
            end
            md_valid    = md_have;
            wb_valid    = ($urandom % 3 != 0) && !m_hold;
            wb_addr     = rand_addr();
            wb_data     = 32'($urandom);
            issue_valid = ($urandom % 4 == 0);
            issue_addr  = rand_addr();
            rs_ena = 1'($urandom); rs_addr = rand_addr();
            rt_ena = 1'($urandom); rt_addr = rand_addr();
            cycle();
            if (last_md_acc) md_have = 0;
        end
        idle_inputs();
        repeat (8) cycle();

        // Reset with two buffered results: everything discarded at once.
        issue_valid = 1; issue_addr = 5'd19;
        cycle();
        issue_addr = 5'd20;
        cycle();
        issue_valid = 0;
        wb_valid = 1; wb_addr = 5'd22; wb_data = 32'h7777;
        md_valid = 1; md_addr = 5'd19; md_data = 32'h1919;
        cycle();
        md_addr = 5'd20; md_data = 32'h2020;
        cycle();
        idle_inputs();
        rs_ena = 1; rs_addr = 5'd19; rt_ena = 1; rt_addr = 5'd20;
        rst_n = 0;
        #1;
        chk("midreset rd_wena", rd_wena, 1'b0);
        chk("midreset md_ready", md_ready, 1'b1);
        chk("midreset hazard_src", hazard_src, 1'b0);
        chk("midreset wb_hold", wb_hold, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
